// File: rtl/sriz_pkg.sv
// sriz_pkg: shared encodings, FSM state type and legality decode for the sriz execute stage.
package sriz_pkg;

  localparam int NUM_REGS = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [31:0] EBREAK_INST = 32'h00100073;
  localparam logic [4:0]  REG_A0      = 5'd10;

  typedef enum logic [1:0] {IDLE, EXEC, HALT} state_t;

  // True for every supported encoding except EBREAK, which is handled as a stop.
  function automatic logic is_legal(input logic [6:0] opcode,
                                    input logic [2:0] func3,
                                    input logic [6:0] func7);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: ok = 1'b1;
      OPC_JALR:   ok = (func3 == 3'd0);
      OPC_BRANCH: ok = (func3 != 3'd2) && (func3 != 3'd3);
      OPC_OP_IMM: begin
        if (func3 == F3_SLL)     ok = (func7 == F7_BASE);
        else if (func3 == F3_SR) ok = (func7 == F7_BASE) || (func7 == F7_ALT);
        else                     ok = 1'b1;
      end
      OPC_OP: ok = (func7 == F7_BASE) ||
                   ((func7 == F7_ALT) && ((func3 == F3_ADD) || (func3 == F3_SR)));
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sriz_regfile.sv
// sriz_regfile: 32x32 integer register file, three combinational reads, one synchronous write.
module sriz_regfile
  import sriz_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] dbg_rdata,
  input  logic            we,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Register storage; x0 is never written so it keeps its cleared value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (rd != 5'd0)) begin
      regs[rd] <= rd_data;
    end
  end

  assign rs1_data  = (rs1 == 5'd0)       ? '0 : regs[rs1];
  assign rs2_data  = (rs2 == 5'd0)       ? '0 : regs[rs2];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

endmodule

// File: rtl/sriz_exu.sv
// sriz_exu: execute/write-back stage of the sriz RV32I core; one instruction per two cycles.
module sriz_exu
  import sriz_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_func3,
  input  logic [11:0]     in_imm12,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc_next,
  output logic            halt,
  output logic [XLEN-1:0] halt_code,
  output logic            illegal,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [31:7]     inst_q;
  logic [6:0]      opcode_q;
  logic [2:0]      func3_q;
  logic [11:0]     imm12_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic            stop_q, bad_q;

  logic            in_legal, in_ebreak;
  logic [4:0]      ra1;
  logic [XLEN-1:0] rv1, rv2;
  logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] opb, pc_plus4, jalr_sum, result, pc_next;
  logic [4:0]      shamt;
  logic            wr_rd, taken, we;

  assign in_legal  = is_legal(in_opcode, in_func3, in_inst[31:25]);
  assign in_ebreak = (in_opcode == OPC_SYSTEM) && (in_inst == EBREAK_INST);
  assign in_ready  = (state == IDLE);

  // A stopping instruction reads no sources, so port 1 is borrowed to capture a0.
  assign ra1 = stop_q ? REG_A0 : rs1_q;

  assign imm_i    = {{(XLEN-12){imm12_q[11]}}, imm12_q};
  assign imm_b    = {{(XLEN-13){inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_u    = {inst_q[31:12], 12'b0};
  assign imm_j    = {{(XLEN-21){inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
  assign opb      = (opcode_q == OPC_OP) ? rv2 : imm_i;
  assign shamt    = opb[4:0];
  assign pc_plus4 = pc_q + XLEN'(4);
  assign jalr_sum = rv1 + imm_i;

  sriz_regfile #(.XLEN(XLEN)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1       (ra1),
    .rs2       (rs2_q),
    .dbg_raddr (dbg_raddr),
    .rs1_data  (rv1),
    .rs2_data  (rv2),
    .dbg_rdata (dbg_rdata),
    .we        (we),
    .rd        (rd_q),
    .rd_data   (result)
  );

  // ALU, branch compare and next-PC selection for the latched instruction.
  always_comb begin
    result  = '0;
    wr_rd   = 1'b0;
    taken   = 1'b0;
    pc_next = pc_plus4;
    case (opcode_q)
      OPC_LUI: begin
        result = imm_u;
        wr_rd  = 1'b1;
      end
      OPC_AUIPC: begin
        result = pc_q + imm_u;
        wr_rd  = 1'b1;
      end
      OPC_JAL: begin
        result  = pc_plus4;
        wr_rd   = 1'b1;
        pc_next = pc_q + imm_j;
      end
      OPC_JALR: begin
        result  = pc_plus4;
        wr_rd   = 1'b1;
        pc_next = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OPC_BRANCH: begin
        case (func3_q)
          F3_BEQ:  taken = (rv1 == rv2);
          F3_BNE:  taken = (rv1 != rv2);
          F3_BLT:  taken = ($signed(rv1) <  $signed(rv2));
          F3_BGE:  taken = ($signed(rv1) >= $signed(rv2));
          F3_BLTU: taken = (rv1 <  rv2);
          F3_BGEU: taken = (rv1 >= rv2);
          default: taken = 1'b0;
        endcase
        if (taken) pc_next = pc_q + imm_b;
      end
      OPC_OP_IMM, OPC_OP: begin
        wr_rd = 1'b1;
        case (func3_q)
          F3_ADD:  result = ((opcode_q == OPC_OP) && inst_q[30]) ? rv1 - opb : rv1 + opb;
          F3_SLL:  result = rv1 << shamt;
          F3_SLT:  result = XLEN'($signed(rv1) < $signed(opb));
          F3_SLTU: result = XLEN'(rv1 < opb);
          F3_XOR:  result = rv1 ^ opb;
          F3_SR:   result = inst_q[30] ? $unsigned($signed(rv1) >>> shamt) : rv1 >> shamt;
          F3_OR:   result = rv1 | opb;
          default: result = rv1 & opb;
        endcase
      end
      default: ;
    endcase
  end

  assign out_pc_next = pc_next;
  assign we          = (state == EXEC) && out_valid && wr_rd;

  // Control FSM: accept in IDLE, execute in EXEC, stop for good in HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      opcode_q  <= '0;
      func3_q   <= '0;
      imm12_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      stop_q    <= 1'b0;
      bad_q     <= 1'b0;
      out_valid <= 1'b0;
      halt      <= 1'b0;
      halt_code <= '0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            pc_q      <= in_pc;
            inst_q    <= in_inst[31:7];
            opcode_q  <= in_opcode;
            func3_q   <= in_func3;
            imm12_q   <= in_imm12;
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            rd_q      <= in_rd;
            out_valid <= in_legal;
            stop_q    <= !in_legal;
            bad_q     <= !in_legal && !in_ebreak;
            state     <= EXEC;
          end
        end
        EXEC: begin
          out_valid <= 1'b0;
          if (stop_q) begin
            state     <= HALT;
            halt      <= 1'b1;
            illegal   <= bad_q;
            halt_code <= rv1;
          end else begin
            state <= IDLE;
          end
        end
        HALT: out_valid <= 1'b0;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sriz_exu.md
Name: sriz_exu

Overview:
- Execute/write-back stage of the sriz RV32I core, directly downstream of the decode unit.
- Accepts one decoded instruction per valid/ready handshake and owns the 32x32 integer register file.
- Computes the result, writes rd, and reports the next PC to the fetch side.
- Halts on EBREAK or on an illegal instruction.

Parameters:
- XLEN, 32, datapath and register width.
- RESET_PC_UNUSED, none: no parameters beyond XLEN. The PC is owned upstream.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  block can accept an instruction
- in_pc  in  32  PC of the instruction
- in_inst  in  32  raw instruction word; supplies func7 and the U/J/B/S immediates
- in_opcode  in  7  decoded opcode (inst[6:0])
- in_func3  in  3  decoded func3
- in_imm12  in  12  decoded I-type immediate (inst[31:20])
- in_rs1, in_rs2, in_rd  in  5 each  decoded register indices
- out_valid  out  1  one-cycle pulse; out_pc_next is valid
- out_pc_next  out  32  next PC
- halt  out  1  sticky stop indication
- halt_code  out  32  x10 (a0) captured at halt
- illegal  out  1  sticky; halt was caused by an unsupported encoding
- dbg_raddr  in  5  debug register read index
- dbg_rdata  out  32  combinational read of x[dbg_raddr]

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All registers x0..x31 = 0.
  - out_valid=0, halt=0, halt_code=0, illegal=0, captured fields = 0.
  - in_ready=1 once rst_n is high.
- FSM states:
  - IDLE: in_ready=1. When in_valid&&in_ready at edge E0, latch all in_* fields and go to EXEC.
  - EXEC: in_ready=0.
    - Read rs1/rs2, compute the result.
    - For a legal non-EBREAK instruction: out_valid=1 for this single cycle; at edge E1 write rd (if rd!=0 and the instruction writes rd), then return to IDLE.
    - For EBREAK (0x00100073) or an illegal encoding: out_valid=0; at E1 go to HALT, set halt=1, set illegal accordingly, and capture halt_code=x10.
  - HALT: in_ready=0, out_valid=0. Absorbing; only reset leaves it.
- Throughput and latency:
  - One instruction every 2 cycles.
  - in_valid while not ready is ignored; upstream must hold its data.
  - Result latency: out_valid is high in the cycle after acceptance.
- Supported instructions (anything else is illegal):
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
  - EBREAK.
  - OP-IMM shifts require funct7 of 0x00, or 0x20 for SRAI only.
  - OP requires funct7 of 0x00, or 0x20 for SUB/SRA only.
- Arithmetic:
  - All operations modulo 2^32.
  - Shift amount = low 5 bits of the operand.
  - SLT/SLTI/BLT/BGE are signed; the U variants are unsigned.
  - Immediates are sign-extended per the RV32I formats.
- Next PC:
  - Default is pc+4.
  - Taken branch and JAL: pc+imm.
  - JALR: (rs1+imm)&~1.
  - JAL/JALR write pc+4 to rd.
  - Misaligned targets are not trapped; they pass through unchanged.
- x0: writes are discarded; reads always return 0, including on dbg_rdata.
- If rd equals rs1 (e.g. ADDI x1,x1,1), the old value is read; the write lands at E1.
- Reset asserted during EXEC: the instruction is aborted, with no register write and no out_valid.

Decomposition:
- Package sriz_pkg:
  - Opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, OP_IMM, OP, SYSTEM).
  - func3 constants for ALU and branch operations.
  - EBREAK encoding constant.
  - State enum {IDLE, EXEC, HALT}.
- Sub-module sriz_regfile:
  - 32x32 storage, 3 combinational read ports (rs1, rs2, debug), 1 synchronous write port.
  - x0 hardwired to zero; same async active-low reset.
- ALU and branch-compare logic stay inline.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) at pc=0 -> out_valid=1 exactly 1 cycle after accept; out_pc_next=4; dbg x1=5; in_ready=0 during EXEC.
- ADDI x0,x0,7 (0x00700013) -> dbg x0=0. Then ADDI x1,x0,-8 (0xff800093) and SRAI x2,x1,1 -> x2=0xFFFFFFFC. SRLI x3,x1,1 -> x3=0x7FFFFFFC. SUB x4,x0,x1 -> x4=8.
- BEQ x0,x0,+16 at pc=0x80000000 -> out_pc_next=0x80000010. BNE x0,x0,+16 -> 0x80000004. JAL x1,+8 at 0x80000004 -> x1=0x80000008, pc_next=0x8000000C. JALR with rs1=0x11, imm=0 -> pc_next=0x10.
- in_valid held high continuously with differing in_pc -> acceptance only in IDLE cycles, i.e. every other cycle; no instruction dropped or duplicated.
- ADDI x10,x0,3 then EBREAK -> halt=1, halt_code=3, illegal=0, no out_valid, in_ready stuck 0. Separately, inst 0xFFFFFFFF -> halt=1, illegal=1.
- rst_n pulsed low during EXEC of ADDI x3,x0,9 -> x3=0, out_valid=0 immediately; after release, state IDLE and in_ready=1.
